// File: rtl/gate_test_sequencer.sv
// Exhaustive stimulus sequencer for small combinational gates: walks every input
// vector, holds it SETTLE cycles, checks the DUT output against a truth table.
module gate_test_sequencer #(
   parameter int                   N_IN   = 2,
   parameter logic [2**N_IN-1:0]   TRUTH  = 4'b1110,
   parameter int                   SETTLE = 4,
   parameter int                   CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [N_IN-1:0]  dut_in,
   input  logic             dut_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [N_IN-1:0]  first_fail,
   output logic             first_fail_vld
);

   localparam int              SC_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SC_W-1:0] SETTLE_LD = SC_W'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [SC_W-1:0] cnt;
   logic            mismatch;

   // Error counter sticks at full scale rather than wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Only consumed on the check edge of RUN; ignored everywhere else.
   assign mismatch = (dut_y != TRUTH[dut_in]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         dut_in         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_fail     <= '0;
         first_fail_vld <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state          <= RUN;
                  dut_in         <= '0;
                  cnt            <= SETTLE_LD;
                  busy           <= 1'b1;
                  err_count      <= '0;
                  first_fail     <= '0;
                  first_fail_vld <= 1'b0;
                  pass           <= 1'b0;
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  if (mismatch) begin
                     err_count <= sat_inc(err_count);
                     if (!first_fail_vld) begin
                        first_fail     <= dut_in;
                        first_fail_vld <= 1'b1;
                     end
                  end
                  if (dut_in != LAST_VEC) begin
                     dut_in <= dut_in + 1'b1;
                     cnt    <= SETTLE_LD;
                  end else begin
                     // Last vector: the final mismatch is not yet in err_count.
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_count == '0) && !mismatch;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: three sequencer instances (default, SETTLE=2, SETTLE=1/CNT_W=1)
// driven against OR, stuck-at-0, AND and delayed-OR models of the gate.
module tb_gate_test_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] start_v = '0;
   int mode = 0;
   int n_cmp = 0;
   int n_err = 0;

   logic [1:0] dut_in0, dut_in1, dut_in2;
   logic       y0, y1;
   logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
   logic [7:0] err0, err1;
   logic [0:0] err2;
   logic [1:0] ff0, ff1, ff2;
   logic       ffv0, ffv1, ffv2;
   logic [2:0] dly0 = '0;
   logic [2:0] dly1 = '0;

   always #5 clk = ~clk;

   // Three-cycle registered OR models for the settle-time check.
   always_ff @(posedge clk) begin
      dly0 <= {dly0[1:0], |dut_in0};
      dly1 <= {dly1[1:0], |dut_in1};
   end

   always_comb begin
      y0 = 1'b0;
      case (mode)
         0: y0 = dut_in0[0] | dut_in0[1];
         1: y0 = 1'b0;
         2: y0 = dut_in0[0] & dut_in0[1];
         default: y0 = dly0[2];
      endcase
   end
   assign y1 = dly1[2];

   gate_test_sequencer u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_in(dut_in0), .dut_y(y0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .first_fail(ff0), .first_fail_vld(ffv0));

   gate_test_sequencer #(.SETTLE(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_in(dut_in1), .dut_y(y1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail(ff1), .first_fail_vld(ffv1));

   gate_test_sequencer #(.SETTLE(1), .CNT_W(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_in(dut_in2), .dut_y(1'b0),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail(ff2), .first_fail_vld(ffv2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic done_of(input int which);
      case (which)
         0: return done0;
         1: return done1;
         default: return done2;
      endcase
   endfunction

   // Pulses start for one edge, returns edges from the start edge to done seen.
   task automatic run_sweep(input int which, output int cycles);
      cycles = 0;
      start_v[which] = 1'b1;
      tick();
      start_v = '0;
      while (!done_of(which) && cycles < 200) begin
         tick();
         cycles++;
      end
   endtask

   int c;
   int done_seen;

   initial begin
      #1;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_pass", int'(pass0), 0);
      chk("rst_dut_in", int'(dut_in0), 0);
      chk("rst_err", int'(err0), 0);
      chk("rst_ffv", int'(ffv0), 0);

      // Correct OR: per-cycle stimulus walk and done timing
      mode = 0;
      start_v[0] = 1'b1;
      tick();
      start_v = '0;
      chk("or_busy_t0", int'(busy0), 1);
      chk("or_vec_t0", int'(dut_in0), 0);
      for (int j = 1; j < 16; j++) begin
         tick();
         chk($sformatf("or_vec_c%0d", j), int'(dut_in0), j / 4);
         chk($sformatf("or_nodone_c%0d", j), int'(done0), 0);
      end
      tick();
      chk("or_done", int'(done0), 1);
      chk("or_busy_end", int'(busy0), 0);
      chk("or_pass", int'(pass0), 1);
      chk("or_err", int'(err0), 0);
      chk("or_ffv", int'(ffv0), 0);
      chk("or_last_vec", int'(dut_in0), 3);
      tick();
      chk("or_done_drop", int'(done0), 0);
      chk("or_pass_hold", int'(pass0), 1);

      // Output stuck at 0
      mode = 1;
      run_sweep(0, c);
      chk("s0_cycles", c, 16);
      chk("s0_err", int'(err0), 3);
      chk("s0_ff", int'(ff0), 1);
      chk("s0_ffv", int'(ffv0), 1);
      chk("s0_pass", int'(pass0), 0);

      // AND substituted for OR
      mode = 2;
      run_sweep(0, c);
      chk("and_cycles", c, 16);
      chk("and_err", int'(err0), 2);
      chk("and_ff", int'(ff0), 1);
      chk("and_pass", int'(pass0), 0);

      // Delayed OR with enough settle time
      mode = 3;
      run_sweep(0, c);
      chk("dly4_pass", int'(pass0), 1);
      chk("dly4_err", int'(err0), 0);

      // Delayed OR with SETTLE=2: vector 01 still sees the output for 00
      run_sweep(1, c);
      chk("dly2_cycles", c, 8);
      chk("dly2_pass", int'(pass1), 0);
      chk("dly2_err", int'(err1), 1);
      chk("dly2_ff", int'(ff1), 1);

      // start re-pulsed mid-sweep is ignored
      mode = 1;
      start_v[0] = 1'b1;
      tick();
      start_v = '0;
      repeat (4) tick();
      start_v[0] = 1'b1;
      tick();
      start_v = '0;
      chk("rs_vec_c5", int'(dut_in0), 1);
      chk("rs_busy_c5", int'(busy0), 1);
      repeat (3) tick();
      start_v[0] = 1'b1;
      tick();
      start_v = '0;
      chk("rs_vec_c9", int'(dut_in0), 2);
      c = 9;
      while (!done0 && c < 200) begin
         tick();
         c++;
      end
      chk("rs_cycles", c, 16);
      chk("rs_err", int'(err0), 3);

      // start during the done cycle launches a fresh sweep
      start_v[0] = 1'b1;
      tick();
      start_v = '0;
      chk("re_done", int'(done0), 0);
      chk("re_busy", int'(busy0), 1);
      chk("re_err", int'(err0), 0);
      chk("re_ffv", int'(ffv0), 0);
      chk("re_vec", int'(dut_in0), 0);

      // Reset for one edge at cycle 7 of the sweep
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("ab_busy", int'(busy0), 0);
      chk("ab_done", int'(done0), 0);
      chk("ab_vec", int'(dut_in0), 0);
      chk("ab_err", int'(err0), 0);
      chk("ab_pass", int'(pass0), 0);
      chk("ab_ffv", int'(ffv0), 0);
      chk("ab_ff", int'(ff0), 0);
      done_seen = 0;
      repeat (20) begin
         tick();
         if (done0) done_seen++;
      end
      chk("ab_no_done", done_seen, 0);
      chk("ab_idle_busy", int'(busy0), 0);

      // SETTLE=1, one-bit counter, output stuck at 0
      run_sweep(2, c);
      chk("s1_cycles", c, 4);
      chk("s1_err_sat", int'(err2), 1);
      chk("s1_pass", int'(pass2), 0);
      chk("s1_ff", int'(ff2), 1);
      chk("s1_ffv", int'(ffv2), 1);
      chk("s1_busy", int'(busy2), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
